// File: rtl/mux_sel_sequencer.sv
// Parallel-in sequencer: captures a word, then walks sel across every index of a
// downstream N:1 mux, one index per accepted output beat, with back-to-back reload.
module mux_sel_sequencer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int M        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] din,
  output logic [N-1:0] word_q,
  output logic [M-1:0] sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [M-1:0] LAST_IDX  = M'(N - 1);
  localparam logic [M-1:0] START_IDX = MSB_FIRST ? LAST_IDX : '0;
  localparam logic [M-1:0] END_IDX   = MSB_FIRST ? '0 : LAST_IDX;

  state_t       state_q, state_d;
  logic [N-1:0] word_d;
  logic [M-1:0] sel_q, sel_d;
  logic         done_q, done_d;
  logic         accept, beat;

  assign out_valid = (state_q == RUN);
  assign out_last  = out_valid && (sel_q == END_IDX);
  // A running word only frees the input on its final consumed beat.
  assign in_ready  = !out_valid || (out_last && out_ready);
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign sel       = sel_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    done_d  = beat && out_last;
    if (accept) begin
      word_d  = din;
      sel_d   = START_IDX;
      state_d = RUN;
    end else if (beat) begin
      if (out_last) begin
        state_d = IDLE;
        sel_d   = '0;
      end else begin
        // Stepping stops at END_IDX, so sel never reaches N..2^M-1.
        sel_d = MSB_FIRST ? sel_q - M'(1) : sel_q + M'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: three sequencer configurations (N=4 LSB-first, N=4 MSB-first, N=5),
// expected beats queued at stimulus time and popped by a negedge monitor.
module tb_mux_sel_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_valid, out_ready;
  logic [7:0] din;
  logic [2:0] ir, ov, ol, dn;
  logic [3:0] wq_a, wq_b;
  logic [4:0] wq_c;
  logic [1:0] sl_a, sl_b;
  logic [2:0] sl_c;
  logic [7:0] wq [3];
  logic [2:0] sl [3];

  always #5 clk = ~clk;

  mux_sel_sequencer #(.N(4), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir[0]), .din(din[3:0]),
    .word_q(wq_a), .sel(sl_a), .out_valid(ov[0]), .out_ready(out_ready[0]),
    .out_last(ol[0]), .done(dn[0]));
  mux_sel_sequencer #(.N(4), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir[1]), .din(din[3:0]),
    .word_q(wq_b), .sel(sl_b), .out_valid(ov[1]), .out_ready(out_ready[1]),
    .out_last(ol[1]), .done(dn[1]));
  mux_sel_sequencer #(.N(5), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir[2]), .din(din[4:0]),
    .word_q(wq_c), .sel(sl_c), .out_valid(ov[2]), .out_ready(out_ready[2]),
    .out_last(ol[2]), .done(dn[2]));

  assign wq[0] = {4'b0, wq_a};
  assign wq[1] = {4'b0, wq_b};
  assign wq[2] = {3'b0, wq_c};
  assign sl[0] = {1'b0, sl_a};
  assign sl[1] = {1'b0, sl_b};
  assign sl[2] = sl_c;

  typedef struct {
    int         k;
    logic [2:0] sel;
    logic       b;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] prev_last = '0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // bits[i] is the serial value of the i-th beat; sel order follows the config
  task automatic push(input int k, input int n, input bit msb, input logic [7:0] bits);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.k    = k;
      e.sel  = msb ? 3'(n - 1 - i) : 3'(i);
      e.b    = bits[i];
      e.last = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send(input int k, input logic [7:0] d);
    chk("in_ready_before_send", {7'b0, ir[k]}, 8'h01);
    in_valid[k] = 1'b1;
    din         = d;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    while (ov[k] && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_timeout", {7'b0, ov[k]}, 8'h00);
  endtask

  // Monitor: beats are compared against the scoreboard; done must follow each last beat.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        prev_last[k] = 1'b0;
      end else begin
        if (prev_last[k] || dn[k]) begin
          n_cmp++;
          if (dn[k] !== prev_last[k]) begin
            n_bad++;
            $display("FAIL done[%0d]: got %b want %b", k, dn[k], prev_last[k]);
          end
        end
        prev_last[k] = 1'b0;
        if (ov[k] && out_ready[k]) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL beat[%0d]: unexpected beat sel=%0d", k, sl[k]);
          end else begin
            e = sb.pop_front();
            if (e.k != k || sl[k] !== e.sel || wq[k][sl[k]] !== e.b || ol[k] !== e.last) begin
              n_bad++;
              $display("FAIL beat[%0d]: got inst=%0d sel=%0d bit=%b last=%b want inst=%0d sel=%0d bit=%b last=%b",
                       k, k, sl[k], wq[k][sl[k]], ol[k], e.k, e.sel, e.b, e.last);
            end
          end
          prev_last[k] = ol[k];
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    din       = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", {7'b0, ov[k]}, 8'h00);
      chk("rst_sel", {5'b0, sl[k]}, 8'h00);
      chk("rst_word", wq[k], 8'h00);
      chk("rst_done", {7'b0, dn[k]}, 8'h00);
    end
    rst_n     = 1'b1;
    out_ready = 3'b111;
    @(posedge clk); #1;

    // N=4 LSB-first, din=1011 -> beats 1,1,0,1
    push(0, 4, 1'b0, 8'b1011);
    send(0, 8'b1011);
    wait_idle(0);
    chk("t1_idle_sel", {5'b0, sl[0]}, 8'h00);
    chk("t1_idle_ready", {7'b0, ir[0]}, 8'h01);

    // N=4 MSB-first, din=0110 -> sel 3,2,1,0 beats 0,1,1,0
    push(1, 4, 1'b1, 8'b0110);
    send(1, 8'b0110);
    wait_idle(1);

    // Stall three cycles at sel=1; din=1100 -> beats 0,0,1,1
    push(0, 4, 1'b0, 8'b1100);
    send(0, 8'b1100);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_sel", {5'b0, sl[0]}, 8'h01);
      chk("stall_word", wq[0], 8'h0C);
      chk("stall_valid", {7'b0, ov[0]}, 8'h01);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("stall_resume_sel", {5'b0, sl[0]}, 8'h02);
    wait_idle(0);

    // Back-to-back: 1011 then 0001 (beats 1,0,0,0), in_valid held through RUN
    push(0, 4, 1'b0, 8'b1011);
    push(0, 4, 1'b0, 8'b0001);
    send(0, 8'b1011);
    in_valid[0] = 1'b1;
    din         = 8'b0001;
    repeat (4) @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    chk("b2b_sel", {5'b0, sl[0]}, 8'h00);
    chk("b2b_word", wq[0], 8'h01);
    chk("b2b_valid", {7'b0, ov[0]}, 8'h01);
    chk("b2b_done", {7'b0, dn[0]}, 8'h01);
    wait_idle(0);

    // N=5, din=10101; mid-word in_valid must be ignored
    push(2, 5, 1'b0, 8'b10101);
    send(2, 8'b10101);
    in_valid[2] = 1'b1;
    din         = 8'b01010;
    repeat (2) begin
      @(posedge clk); #1;
      chk("n5_ignore_word", wq[2], 8'h15);
      chk("n5_ignore_ready", {7'b0, ir[2]}, 8'h00);
    end
    in_valid[2] = 1'b0;
    wait_idle(2);
    chk("n5_idle_sel", {5'b0, sl[2]}, 8'h00);

    // Reset mid-word at sel=2
    push(0, 4, 1'b0, 8'b1011);
    send(0, 8'b1011);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pre_sel", {5'b0, sl[0]}, 8'h02);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    chk("abort_valid", {7'b0, ov[0]}, 8'h00);
    chk("abort_sel", {5'b0, sl[0]}, 8'h00);
    chk("abort_word", wq[0], 8'h00);
    chk("abort_ready", {7'b0, ir[0]}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {7'b0, dn[0]}, 8'h00);
    end

    chk("sb_empty", 8'(sb.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
